// File: rtl/aes_sbox_pkg.sv
// rtl/aes_sbox_pkg.sv - AES forward/inverse S-box tables and lookup helpers
// Shared by aes_sbox_lane; the forward table is only referenced when AES_SBOX_FWD_EN is defined.
package aes_sbox_pkg;

   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [BYTE_W-1:0] SBOX_INV [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [BYTE_W-1:0] sbox_fwd(input logic [BYTE_W-1:0] b);
      return SBOX_FWD[b];
   endfunction

   function automatic logic [BYTE_W-1:0] sbox_inv(input logic [BYTE_W-1:0] b);
      return SBOX_INV[b];
   endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// rtl/aes_sbox_lane.sv - combinational single-byte S-box lookup with inverse select
// The forward table exists only under AES_SBOX_FWD_EN; otherwise inv is ignored.
module aes_sbox_lane
   import aes_sbox_pkg::*;
(
   input  logic              inv,
   input  logic [BYTE_W-1:0] in_byte,
   output logic [BYTE_W-1:0] out_byte
);

`ifdef AES_SBOX_FWD_EN
   always_comb begin
      out_byte = inv ? sbox_inv(in_byte) : sbox_fwd(in_byte);
   end
`else
   logic unused_inv;
   assign unused_inv = inv;

   always_comb begin
      out_byte = sbox_inv(in_byte);
   end
`endif

endmodule

// File: rtl/aes_sub_bytes_pipe.sv
// rtl/aes_sub_bytes_pipe.sv - two-stage elastic multi-lane AES SubBytes/InvSubBytes engine
// AES_SBOX_FWD_EN enables per-beat forward/inverse select; without it every beat is InvSbox.
module aes_sub_bytes_pipe
   import aes_sbox_pkg::*;
#(
   parameter int LANES = 16,
   parameter int TAG_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_inv,
   input  logic [BYTE_W*LANES-1:0]   in_data,
   input  logic [TAG_W-1:0]          in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BYTE_W*LANES-1:0]   out_data,
   output logic [TAG_W-1:0]          out_tag,
   output logic                      out_inv,
   output logic                      busy
);

   localparam int DW = BYTE_W * LANES;

   logic            s1_valid_q, s1_valid_d;
   logic [DW-1:0]   s1_data_q,  s1_data_d;
   logic            s1_inv_q,   s1_inv_d;
   logic [TAG_W-1:0] s1_tag_q,  s1_tag_d;

   logic            s2_valid_q, s2_valid_d;
   logic [DW-1:0]   s2_data_q,  s2_data_d;
   logic            s2_inv_q,   s2_inv_d;
   logic [TAG_W-1:0] s2_tag_q,  s2_tag_d;

   logic            adv1, adv2;
   logic [DW-1:0]   sub_data;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      aes_sbox_lane u_lane (
         .inv      (s1_inv_q),
         .in_byte  (s1_data_q[BYTE_W*k +: BYTE_W]),
         .out_byte (sub_data[BYTE_W*k +: BYTE_W])
      );
   end

   // in_ready depends only on the valid flags and out_ready, never on in_valid.
   always_comb begin
      adv2 = !s2_valid_q || out_ready;
      adv1 = !s1_valid_q || adv2;

      s1_valid_d = adv1 ? in_valid : s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_inv_d   = s1_inv_q;
      s1_tag_d   = s1_tag_q;
      if (adv1 && in_valid) begin
         s1_data_d = in_data;
         s1_inv_d  = in_inv;
         s1_tag_d  = in_tag;
      end

      s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_inv_d   = s2_inv_q;
      s2_tag_d   = s2_tag_q;
      if (adv2 && s1_valid_q) begin
         s2_data_d = sub_data;
         s2_tag_d  = s1_tag_q;
`ifdef AES_SBOX_FWD_EN
         s2_inv_d  = s1_inv_q;
`else
         s2_inv_d  = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_inv_q   <= 1'b0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_inv_q   <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_inv_q   <= s1_inv_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_inv_q   <= s2_inv_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign in_ready  = adv1;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_tag   = s2_tag_q;
   assign out_inv   = s2_inv_q;
   assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// tb/tb_aes_sub_bytes_pipe.sv - scoreboard bench for aes_sub_bytes_pipe
// Reference S-boxes are derived from GF(2^8) inversion plus the AES affine map.
module tb_aes_sub_bytes_pipe;

   localparam int LANES = 16;
   localparam int TAG_W = 4;
   localparam int DW    = 8 * LANES;

   typedef struct {
      logic [DW-1:0]    data;
      logic [TAG_W-1:0] tag;
      logic             inv;
      int               cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_inv = 1'b0;
   logic [DW-1:0]    in_data = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [DW-1:0]    out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_inv;
   logic             busy;

   logic [7:0] m_fwd [256];
   logic [7:0] m_inv [256];

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_acc = 0;
   int   n_out = 0;
   int   cyc = 0;
   logic check_lat = 1'b0;
   logic gap_chk = 1'b0;
   logic ovr_en = 1'b0;
   logic [DW-1:0] ovr_data = '0;

   logic             stalled = 1'b0;
   logic [DW-1:0]    prev_data;
   logic [TAG_W-1:0] prev_tag;
   logic             prev_inv;

   aes_sub_bytes_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inv    (in_inv),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_inv   (out_inv),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   function automatic logic [7:0] ref_sbox(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
      return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
   endfunction

   function automatic logic eff_inv(input logic inv);
`ifdef AES_SBOX_FWD_EN
      return inv;
`else
      return 1'b1 | inv;
`endif
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected-response capture, just after the monitor in each cycle.
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (!rst && in_valid && in_ready) begin
         e.inv = eff_inv(in_inv);
         for (int k = 0; k < LANES; k++)
            e.data[8*k +: 8] = e.inv ? m_inv[in_data[8*k +: 8]] : m_fwd[in_data[8*k +: 8]];
         if (ovr_en) e.data = ovr_data;
         e.tag = in_tag;
         e.cyc = cyc;
         q.push_back(e);
         n_acc++;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         stalled = 1'b0;
      end else begin
         check("busy", DW'(busy), DW'(q.size() != 0));
         check("occupancy", DW'(q.size() <= 2), DW'(1));
         if (stalled) begin
            check("stall valid", DW'(out_valid), DW'(1));
            check("stall data", out_data, prev_data);
            check("stall tag", DW'(out_tag), DW'(prev_tag));
            check("stall inv", DW'(out_inv), DW'(prev_inv));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious output", DW'(1), DW'(0));
            end else begin
               e = q.pop_front();
               n_out++;
               check("out_data", out_data, e.data);
               check("out_tag", DW'(out_tag), DW'(e.tag));
               check("out_inv", DW'(out_inv), DW'(e.inv));
               if (check_lat) check("latency", DW'(cyc - e.cyc), DW'(2));
            end
         end
         stalled   = out_valid && !out_ready;
         prev_data = out_data;
         prev_tag  = out_tag;
         prev_inv  = out_inv;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [DW-1:0] d, input logic inv, input logic [TAG_W-1:0] t);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_inv   = inv;
      in_tag   = t;
      do begin
         @(negedge clk);
         n++;
      end while (!(in_ready && !rst) && n < 500);
      if (gap_chk) check("in_ready gap", DW'(n), DW'(1));
      if (!in_ready) check("accept timeout", DW'(0), DW'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain timeout", DW'(q.size() == 0 && !busy), DW'(1));
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom;
      return d;
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      logic [DW-1:0] x;
      int acc0, out0;
      bit done;

      for (int i = 0; i < 256; i++) m_fwd[i] = ref_sbox(8'(i));
      for (int i = 0; i < 256; i++) m_inv[m_fwd[i]] = 8'(i);

      // Power-on reset with a beat offered that must be discarded.
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = rand_data();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("in_ready in rst", DW'(in_ready), DW'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst out_valid", DW'(out_valid), DW'(0));
      check("rst busy", DW'(busy), DW'(0));
      check("rst in_ready", DW'(in_ready), DW'(1));
      check("rst out_data", out_data, DW'(0));
      check("rst out_tag", DW'(out_tag), DW'(0));
      check("rst out_inv", DW'(out_inv), DW'(0));
      @(posedge clk);
      #1;

      // Directed inverse vectors, lanes 0..5; remaining lanes are 0x00 -> 0x52.
      check_lat = 1'b1;
      ovr_en = 1'b1;
      ovr_data = {{10{8'h52}}, 8'h7d, 8'h53, 8'h48, 8'h01, 8'h00, 8'h52};
      send({{10{8'h00}}, 8'hff, 8'hed, 8'h52, 8'h7c, 8'h63, 8'h00}, 1'b1, 4'h1);
      ovr_en = 1'b0;
      drain();

`ifdef AES_SBOX_FWD_EN
      ovr_en = 1'b1;
      ovr_data = {{13{8'h63}}, 8'hed, 8'h7c, 8'h63};
      send({{13{8'h00}}, 8'h53, 8'h01, 8'h00}, 1'b0, 4'h2);
      x = ovr_data;
      ovr_data = {{13{8'h00}}, 8'h53, 8'h01, 8'h00};
      send(x, 1'b1, 4'h3);
      ovr_en = 1'b0;
      drain();
`endif

      // Exhaustive back-to-back sweep with alternating mode.
      gap_chk = 1'b1;
      for (int i = 0; i < 256; i++) begin
         for (int k = 0; k < LANES; k++) d[8*k +: 8] = 8'(i + k);
         send(d, i[0], TAG_W'(i));
      end
      gap_chk = 1'b0;
      drain();
      check_lat = 1'b0;

      // Backpressure: two beats fill the pipe, the third must wait.
      acc0 = n_acc;
      out_ready = 1'b0;
      send(rand_data(), 1'b1, 4'd0);
      send(rand_data(), 1'b0, 4'd1);
      in_valid = 1'b1;
      in_data = rand_data();
      in_inv = 1'b1;
      in_tag = 4'd2;
      repeat (4) begin
         @(negedge clk);
         check("bp in_ready", DW'(in_ready), DW'(0));
      end
      check("bp accepted", DW'(n_acc - acc0), DW'(2));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp in_ready release", DW'(in_ready), DW'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      send(rand_data(), 1'b0, 4'd3);
      send(rand_data(), 1'b1, 4'd4);
      drain();
      check("bp total", DW'(n_acc - acc0), DW'(5));

      // Random traffic, 50% in_valid and 50% out_ready.
      acc0 = n_acc;
      out0 = n_out;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               while ($urandom_range(0, 1) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(rand_data(), 1'($urandom_range(0, 1)), TAG_W'(i));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("rand accepted", DW'(n_acc - acc0), DW'(10000));
      check("rand delivered", DW'(n_out - out0), DW'(n_acc - acc0));

      // Reset with a full pipe flushes everything.
      out_ready = 1'b0;
      send(rand_data(), 1'b1, 4'h5);
      send(rand_data(), 1'b1, 4'h6);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = rand_data();
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush out_valid", DW'(out_valid), DW'(0));
      check("flush busy", DW'(busy), DW'(0));
      check("flush in_ready", DW'(in_ready), DW'(1));
      check("flush out_data", out_data, DW'(0));
      check("flush out_tag", DW'(out_tag), DW'(0));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      check_lat = 1'b1;
      acc0 = n_acc;
      out0 = n_out;
      send(rand_data(), 1'b1, 4'h7);
      drain();
      check("post-rst delivered", DW'(n_out - out0), DW'(1));
      check_lat = 1'b0;

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
